// File: rtl/move_stack.sv
`default_nettype none
// ============================================================================
//  Module   : move_stack
//  Purpose  : LIFO stack of 2-bit solver move codes. Moves are pushed on
//             expand and popped on backtrack. The path freezes when the
//             solver reports the goal. Any overflow or underflow parks the
//             stack in a sticky error state until clr.
//  Ports    :
//    clk   in   1        system clock, all state on posedge
//    rst   in   1        asynchronous active-high reset
//    clr   in   1        synchronous clear back to an empty BUILD stack
//    push  in   1        push mv onto the stack
//    pop   in   1        remove the top move
//    mv    in   2        move code (UP=0, DOWN=1, RIGHT=2, LEFT=3)
//    done  in   1        goal reached, freeze the path
//    ord   out  2*DEPTH  packed path, slot i = ord[2i+1:2i], slot 0 first
//    len   out  LEN_W    number of valid moves
//    top   out  2        code in slot len-1, 0 when empty
//    comp  out  1        path complete and frozen
//    full  out  1        len == DEPTH
//    empty out  1        len == 0
//    err   out  1        sticky overflow/underflow flag
//  Revision : 1.0  initial release
// ============================================================================
module move_stack #(
  parameter int DEPTH = 17,
  parameter int LEN_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic [1:0]           mv,
  input  logic                 done,
  output logic [2*DEPTH-1:0]   ord,
  output logic [LEN_W-1:0]     len,
  output logic [1:0]           top,
  output logic                 comp,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  typedef enum logic [1:0] {
    BUILD = 2'd0,
    DONE  = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [2*DEPTH-1:0] ord_n;
  logic [LEN_W-1:0]   len_n;
  logic               wr_en;
  logic [LEN_W-1:0]   wr_idx;
  logic [1:0]         wr_val;
  logic               illegal;

  assign full  = (len == LEN_W'(DEPTH));
  assign empty = (len == '0);
  assign comp  = (state == DONE);
  assign err   = (state == ERR);

  // Top-of-stack is decoded from the registered path and length.
  always_comb begin
    top = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      if (len == LEN_W'(i + 1)) top = ord[2*i +: 2];
    end
  end

  // Next-state logic. At most one slot is written per cycle; wr_idx/wr_val
  // describe that write. Pops write 0 so vacated slots always read back 0.
  always_comb begin
    ord_n   = ord;
    len_n   = len;
    state_n = state;
    wr_en   = 1'b0;
    wr_idx  = len;
    wr_val  = mv;
    illegal = 1'b0;

    if (clr) begin
      ord_n   = '0;
      len_n   = '0;
      state_n = BUILD;
    end else if (state == BUILD) begin
      if (push && pop) begin
        // Replace top; on an empty stack this degenerates to a plain push.
        wr_en = 1'b1;
        if (empty) begin
          wr_idx = len;
          len_n  = len + LEN_W'(1);
        end else begin
          wr_idx = len - LEN_W'(1);
        end
      end else if (push) begin
        if (full) begin
          illegal = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = len;
          len_n  = len + LEN_W'(1);
        end
      end else if (pop) begin
        if (empty) begin
          illegal = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = len - LEN_W'(1);
          wr_val = 2'b00;
          len_n  = len - LEN_W'(1);
        end
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_idx == LEN_W'(i))) ord_n[2*i +: 2] = wr_val;
      end

      // An illegal op beats a simultaneous done.
      if (illegal)   state_n = ERR;
      else if (done) state_n = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord   <= '0;
      len   <= '0;
      state <= BUILD;
    end else begin
      ord   <= ord_n;
      len   <= len_n;
      state <= state_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_move_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_stack
//  Purpose  : Directed testbench for move_stack. Stimulus pushes expected
//             output snapshots into a queue. A monitor pops each snapshot on
//             the next falling edge and compares it with the DUT outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_move_stack;

  localparam int DEPTH = 17;
  localparam int LEN_W = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               push = 1'b0;
  logic               pop = 1'b0;
  logic [1:0]         mv = 2'b00;
  logic               done = 1'b0;
  logic [2*DEPTH-1:0] ord;
  logic [LEN_W-1:0]   len;
  logic [1:0]         top;
  logic               comp, full, empty, err;

  typedef struct {
    int                 id;
    logic [2*DEPTH-1:0] ord;
    logic [LEN_W-1:0]   len;
    logic [1:0]         top;
    logic               comp;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  move_stack #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .mv(mv),
    .done(done), .ord(ord), .len(len), .top(top), .comp(comp),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic e_full, e_empty;
      e       = exp_q.pop_front();
      e_full  = (e.len == LEN_W'(DEPTH));
      e_empty = (e.len == '0);
      checks++;
      if (ord !== e.ord || len !== e.len || top !== e.top || comp !== e.comp ||
          err !== e.err || full !== e_full || empty !== e_empty) begin
        errors++;
        $display("FAIL chk%0d: got ord=%h len=%0d top=%0d comp=%b err=%b full=%b empty=%b; want ord=%h len=%0d top=%0d comp=%b err=%b full=%b empty=%b",
                 e.id, ord, len, top, comp, err, full, empty,
                 e.ord, e.len, e.top, e.comp, e.err, e_full, e_empty);
      end
    end
  end

  int next_id = 0;

  task automatic expect_out(input logic [2*DEPTH-1:0] o, input int l,
                            input logic [1:0] t, input logic c, input logic e);
    exp_t x;
    x.id   = next_id;
    x.ord  = o;
    x.len  = LEN_W'(l);
    x.top  = t;
    x.comp = c;
    x.err  = e;
    next_id++;
    exp_q.push_back(x);
  endtask

  // One clock cycle with the given controls, then return them to idle.
  task automatic cyc(input logic p, input logic q, input logic [1:0] m,
                     input logic d, input logic c);
    push = p; pop = q; mv = m; done = d; clr = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; done = 1'b0; clr = 1'b0;
  endtask

  task automatic do_clr();
    cyc(0, 0, 2'd0, 0, 1);
    expect_out('0, 0, 2'd0, 0, 0);
  endtask

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, RIGHT = 2'd2, LEFT = 2'd3;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    expect_out('0, 0, 2'd0, 0, 0);
    rst = 1'b0;

    // 1: UP, RIGHT, DOWN then done; later push ignored
    cyc(1, 0, UP, 0, 0);    expect_out(34'h0,  1, UP, 0, 0);
    cyc(1, 0, RIGHT, 0, 0); expect_out(34'h8,  2, RIGHT, 0, 0);
    cyc(1, 0, DOWN, 0, 0);  expect_out(34'h18, 3, DOWN, 0, 0);
    cyc(0, 0, UP, 1, 0);    expect_out(34'h18, 3, DOWN, 1, 0);
    cyc(1, 0, LEFT, 0, 0);  expect_out(34'h18, 3, DOWN, 1, 0);
    cyc(0, 1, UP, 0, 0);    expect_out(34'h18, 3, DOWN, 1, 0);
    do_clr();

    // 2: LEFT, LEFT, UP, pop, pop, then replace-top with DOWN
    cyc(1, 0, LEFT, 0, 0);  expect_out(34'h3, 1, LEFT, 0, 0);
    cyc(1, 0, LEFT, 0, 0);  expect_out(34'hF, 2, LEFT, 0, 0);
    cyc(1, 0, UP, 0, 0);    expect_out(34'hF, 3, UP, 0, 0);
    cyc(0, 1, UP, 0, 0);    expect_out(34'hF, 2, LEFT, 0, 0);
    cyc(0, 1, UP, 0, 0);    expect_out(34'h3, 1, LEFT, 0, 0);
    cyc(1, 1, DOWN, 0, 0);  expect_out(34'h1, 1, DOWN, 0, 0);
    do_clr();

    // 3: fill with RIGHT, overflow, done ignored in ERR, clr recovers
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, RIGHT, 0, 0);
    expect_out(34'h2_AAAA_AAAA, 17, RIGHT, 0, 0);
    cyc(1, 1, LEFT, 0, 0);  expect_out(34'h3_AAAA_AAAA, 17, LEFT, 0, 0);
    cyc(1, 1, RIGHT, 0, 0); expect_out(34'h2_AAAA_AAAA, 17, RIGHT, 0, 0);
    cyc(1, 0, RIGHT, 0, 0); expect_out(34'h2_AAAA_AAAA, 17, RIGHT, 0, 1);
    cyc(0, 0, UP, 1, 0);    expect_out(34'h2_AAAA_AAAA, 17, RIGHT, 0, 1);
    cyc(0, 1, UP, 0, 0);    expect_out(34'h2_AAAA_AAAA, 17, RIGHT, 0, 1);
    do_clr();

    // 4: pop from empty after reset, then push+pop on empty after clr
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    expect_out('0, 0, 2'd0, 0, 0);
    cyc(0, 1, UP, 0, 0);    expect_out('0, 0, 2'd0, 0, 1);
    do_clr();
    cyc(1, 1, RIGHT, 0, 0); expect_out(34'h2, 1, RIGHT, 0, 0);
    do_clr();

    // 5: push with done, done on empty path, illegal pop with done
    cyc(1, 0, UP, 1, 0);    expect_out('0, 1, UP, 1, 0);
    do_clr();
    cyc(0, 0, UP, 1, 0);    expect_out('0, 0, 2'd0, 1, 0);
    do_clr();
    cyc(0, 1, UP, 1, 0);    expect_out('0, 0, 2'd0, 0, 1);
    // clr beats simultaneous push
    cyc(1, 0, LEFT, 0, 1);  expect_out('0, 0, 2'd0, 0, 0);

    // 6: async reset pulse between edges at len=5
    cyc(1, 0, RIGHT, 0, 0);
    cyc(1, 0, DOWN, 0, 0);
    cyc(1, 0, LEFT, 0, 0);
    cyc(1, 0, UP, 0, 0);
    cyc(1, 0, RIGHT, 0, 0); expect_out(34'h236, 5, RIGHT, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    expect_out('0, 0, 2'd0, 0, 0);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    cyc(1, 0, UP, 0, 0);    expect_out('0, 1, UP, 0, 0);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
